// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter generator.
package pc_pkg;

  localparam int          DEFAULT_XLEN         = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          DEFAULT_INSTR_BYTES  = 4;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_TRAP
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_BR,
    SEL_JMP,
    SEL_TRAP,
    SEL_RET
  } npc_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux with redirect-target alignment.
// PC_MISALIGN_TRAP_EN turns misaligned jump/branch targets into trap entries.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int               XLEN        = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]  TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int               INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input  logic            boot,
  input  logic            in_trap,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign_hit,
`endif
  output logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] trap_epc,
  output npc_sel_t        sel
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);

  logic            redir;
  logic [XLEN-1:0] redir_target;
  npc_sel_t        redir_sel;

  // A jump outranks a branch resolved in the same cycle.
  assign redir        = jmp_valid | br_taken;
  assign redir_target = jmp_valid ? jmp_target : br_target;
  assign redir_sel    = jmp_valid ? SEL_JMP : SEL_BR;

  always_comb begin
    sel      = SEL_SEQ;
    npc      = pc + XLEN'(INSTR_BYTES);
    trap_epc = trap_pc;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_hit = 1'b0;
`endif
    if (boot) begin
      sel = SEL_HOLD;
      npc = pc;
    end else if (trap_req) begin
      sel = SEL_TRAP;
      npc = TRAP_VECTOR;
    end else if (mret && in_trap) begin
      sel = SEL_RET;
      npc = epc;
    end else if (redir) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (|(redir_target & LOW_MASK)) begin
        sel          = SEL_TRAP;
        npc          = TRAP_VECTOR;
        trap_epc     = redir_target;
        misalign_hit = 1'b1;
      end else begin
        sel = redir_sel;
        npc = redir_target;
      end
`else
      sel = redir_sel;
      npc = redir_target & ~LOW_MASK;
`endif
    end else if (stall || !fetch_ready) begin
      sel = SEL_HOLD;
      npc = pc;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: PC/EPC registers and BOOT/RUN/TRAP state machine.
// Optional misaligned-redirect trapping is enabled by PC_MISALIGN_TRAP_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int               INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic            pc_valid,
  output logic            in_trap,
  output logic [XLEN-1:0] epc,
  output logic            misalign
);

  pc_state_t       state, state_nxt;
  npc_sel_t        sel;
  logic [XLEN-1:0] trap_epc;
`ifdef PC_MISALIGN_TRAP_EN
  logic            misalign_hit;
`endif

  pc_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .boot         (state == ST_BOOT),
    .in_trap      (state == ST_TRAP),
    .pc           (pc),
    .epc          (epc),
    .stall        (stall),
    .fetch_ready  (fetch_ready),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .trap_req     (trap_req),
    .trap_pc      (trap_pc),
    .mret         (mret),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign_hit (misalign_hit),
`endif
    .npc          (npc),
    .trap_epc     (trap_epc),
    .sel          (sel)
  );

  // EPC is only captured on entry from RUN, so a trap inside the handler keeps the original return point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BOOT;
      pc    <= RESET_VECTOR;
      epc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= npc;
      if (state == ST_RUN && sel == SEL_TRAP) begin
        epc <= trap_epc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN:  if (sel == SEL_TRAP) state_nxt = ST_TRAP;
      ST_TRAP: if (sel == SEL_RET)  state_nxt = ST_RUN;
      default: state_nxt = ST_BOOT;
    endcase
  end

  assign pc_valid = (state != ST_BOOT);
  assign in_trap  = (state == ST_TRAP);

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= misalign_hit;
    end
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table plus boot, misalign, wrap and async-reset sequences.
module tb_pc_gen;

  typedef struct {
    logic        stall;
    logic        fetch_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic        mret;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
    logic        exp_in_trap;
    logic        exp_misalign;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, fetch_ready, br_taken, jmp_valid, trap_req, mret;
  logic [31:0] br_target, jmp_target, trap_pc;
  logic [31:0] pc, npc, epc;
  logic        pc_valid, in_trap, misalign;

  int passCount  = 0;
  int checkCount = 0;

  vec_t vecs[20];

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .fetch_ready (fetch_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .trap_req    (trap_req),
    .trap_pc     (trap_pc),
    .mret        (mret),
    .pc          (pc),
    .npc         (npc),
    .pc_valid    (pc_valid),
    .in_trap     (in_trap),
    .epc         (epc),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic st, logic fr, logic br, logic [31:0] brt,
                              logic jv, logic [31:0] jt, logic tr, logic [31:0] tpc,
                              logic mr, logic [31:0] epcv, logic [31:0] eepc,
                              logic etrap, logic emis);
    vec_t v;
    v.stall = st;      v.fetch_ready = fr;
    v.br_taken = br;   v.br_target = brt;
    v.jmp_valid = jv;  v.jmp_target = jt;
    v.trap_req = tr;   v.trap_pc = tpc;
    v.mret = mr;
    v.exp_pc = epcv;   v.exp_epc = eepc;
    v.exp_in_trap = etrap; v.exp_misalign = emis;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    stall       = v.stall;
    fetch_ready = v.fetch_ready;
    br_taken    = v.br_taken;
    br_target   = v.br_target;
    jmp_valid   = v.jmp_valid;
    jmp_target  = v.jmp_target;
    trap_req    = v.trap_req;
    trap_pc     = v.trap_pc;
    mret        = v.mret;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector, check npc before the edge, then the registered outputs after it.
  task automatic runVector(input string tag, input vec_t v);
    applyStimulus(v);
    #1;
    checkOutput($sformatf("%s npc", tag), npc, v.exp_pc);
    stepCycle();
    checkOutput($sformatf("%s pc", tag), pc, v.exp_pc);
    checkOutput($sformatf("%s epc", tag), epc, v.exp_epc);
    checkOutput($sformatf("%s in_trap", tag), {31'b0, in_trap}, {31'b0, v.exp_in_trap});
    checkOutput($sformatf("%s pc_valid", tag), {31'b0, pc_valid}, 32'd1);
    checkOutput($sformatf("%s misalign", tag), {31'b0, misalign}, {31'b0, v.exp_misalign});
  endtask

  vec_t idle;
  logic [31:0] lastEpc;

  initial begin
    idle = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //         st fr br brt    jv jt     tr tpc    mr exp_pc  exp_epc trap mis
    vecs[0]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h0C,  32'h0,  0, 0);
    vecs[1]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h10,  32'h0,  0, 0);
    vecs[2]  = mk(1, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h10,  32'h0,  0, 0);
    vecs[3]  = mk(1, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h10,  32'h0,  0, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h10,  32'h0,  0, 0);
    vecs[5]  = mk(1, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h10,  32'h0,  0, 0);
    vecs[6]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h14,  32'h0,  0, 0);
    vecs[7]  = mk(1, 1, 1, 32'h40, 1, 32'h80, 0, 32'h0,  0, 32'h80,  32'h0,  0, 0);
    vecs[8]  = mk(0, 0, 1, 32'h40, 0, 32'h0,  0, 32'h0,  0, 32'h40,  32'h0,  0, 0);
    vecs[9]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h44,  32'h0,  0, 0);
    vecs[10] = mk(0, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h48,  32'h0,  0, 0);
    vecs[11] = mk(0, 1, 0, 32'h0,  0, 32'h0,  1, 32'h24, 0, 32'h100, 32'h24, 1, 0);
    vecs[12] = mk(0, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h104, 32'h24, 1, 0);
    vecs[13] = mk(0, 1, 0, 32'h0,  0, 32'h0,  1, 32'h104,0, 32'h100, 32'h24, 1, 0);
    vecs[14] = mk(0, 1, 0, 32'h0,  0, 32'h0,  1, 32'h200,1, 32'h100, 32'h24, 1, 0);
    vecs[15] = mk(0, 1, 0, 32'h0,  1, 32'h300,0, 32'h0,  0, 32'h300, 32'h24, 1, 0);
    vecs[16] = mk(1, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h24,  32'h24, 0, 0);
    vecs[17] = mk(0, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0, 32'h28,  32'h24, 0, 0);
    vecs[18] = mk(1, 0, 0, 32'h0,  1, 32'h80, 1, 32'h50, 0, 32'h100, 32'h50, 1, 0);
    vecs[19] = mk(0, 1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  1, 32'h50,  32'h50, 0, 0);

    // Reset held for three cycles
    applyStimulus(idle);
    rst = 1'b1;
    repeat (3) stepCycle();
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset epc", epc, 32'h0);
    checkOutput("reset in_trap", {31'b0, in_trap}, 32'd0);
    checkOutput("reset pc_valid", {31'b0, pc_valid}, 32'd0);
    checkOutput("reset misalign", {31'b0, misalign}, 32'd0);

    // BOOT cycle: requests are ignored and pc is held
    rst = 1'b0;
    applyStimulus(mk(0, 1, 1, 32'h40, 1, 32'h80, 1, 32'h24, 0, 0, 0, 0, 0));
    #1;
    checkOutput("boot pc_valid", {31'b0, pc_valid}, 32'd0);
    checkOutput("boot npc", npc, 32'h0);
    stepCycle();
    checkOutput("boot-exit pc", pc, 32'h0);
    checkOutput("boot-exit pc_valid", {31'b0, pc_valid}, 32'd1);
    checkOutput("boot-exit in_trap", {31'b0, in_trap}, 32'd0);
    checkOutput("boot-exit epc", epc, 32'h0);
    applyStimulus(idle);
    stepCycle();
    checkOutput("seq pc 4", pc, 32'h4);
    stepCycle();
    checkOutput("seq pc 8", pc, 32'h8);

    for (int i = 0; i < 20; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Misaligned redirect handling, pc=0x50, epc=0x50, RUN
`ifdef PC_MISALIGN_TRAP_EN
    runVector("mis jmp", mk(0, 1, 0, 32'h0, 1, 32'h42, 0, 32'h0, 0, 32'h100, 32'h42, 1, 1));
    runVector("mis clear", mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h104, 32'h42, 1, 0));
    runVector("mis nested", mk(0, 1, 0, 32'h0, 1, 32'h42, 1, 32'h10, 0, 32'h100, 32'h42, 1, 0));
    runVector("mis ret1", mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h42, 32'h42, 0, 0));
    runVector("mis ext wins", mk(0, 1, 1, 32'h47, 0, 32'h0, 1, 32'h88, 0, 32'h100, 32'h88, 1, 0));
    runVector("mis ret2", mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h88, 32'h88, 0, 0));
    runVector("mis br", mk(0, 1, 1, 32'h46, 0, 32'h0, 0, 32'h0, 0, 32'h100, 32'h46, 1, 1));
    runVector("mis ret3", mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h46, 32'h46, 0, 0));
    lastEpc = 32'h46;
`else
    runVector("align jmp", mk(0, 1, 0, 32'h0, 1, 32'h42, 0, 32'h0, 0, 32'h40, 32'h50, 0, 0));
    runVector("align br", mk(0, 1, 1, 32'h47, 0, 32'h0, 0, 32'h0, 0, 32'h44, 32'h50, 0, 0));
    runVector("align jmp+br", mk(1, 1, 1, 32'h40, 1, 32'h82, 0, 32'h0, 0, 32'h80, 32'h50, 0, 0));
    lastEpc = 32'h50;
`endif

    // Sequential increment wraps at the top of the address space
    runVector("wrap load", mk(0, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'hFFFF_FFFC, lastEpc, 0, 0));
    runVector("wrap", mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, lastEpc, 0, 0));
    runVector("pre-rst trap", mk(0, 1, 0, 32'h0, 0, 32'h0, 1, 32'h24, 0, 32'h100, 32'h24, 1, 0));

    // Asynchronous reset mid-cycle while in TRAP
    applyStimulus(idle);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async pc", pc, 32'h0);
    checkOutput("async epc", epc, 32'h0);
    checkOutput("async in_trap", {31'b0, in_trap}, 32'd0);
    checkOutput("async pc_valid", {31'b0, pc_valid}, 32'd0);
    stepCycle();
    rst = 1'b0;
    stepCycle();
    checkOutput("reboot pc", pc, 32'h0);
    checkOutput("reboot pc_valid", {31'b0, pc_valid}, 32'd1);
    stepCycle();
    checkOutput("reboot seq", pc, 32'h4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
